// File: rtl/issue_pkg.sv
// Shared decode constants, issue-packet layout and the instruction field splitter
// used by the issue unit and its instruction queue.
package issue_pkg;

  localparam logic [5:0] OP_RTYPE   = 6'h00;
  localparam int         LABEL_NONE = 0;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  rs;
    logic [4:0]  rt;
    logic [4:0]  target;
    logic [5:0]  func;
    logic [15:0] imm16;
  } issue_pkt_t;

  // R-type writes rd, everything else writes rt.
  function automatic issue_pkt_t decode_ins(input logic [31:0] ins);
    issue_pkt_t p;
    p.op     = ins[31:26];
    p.rs     = ins[25:21];
    p.rt     = ins[20:16];
    p.target = (ins[31:26] == OP_RTYPE) ? ins[15:11] : ins[20:16];
    p.func   = ins[5:0];
    p.imm16  = ins[15:0];
    return p;
  endfunction

endpackage

// File: rtl/issue_fifo.sv
// Instruction queue: DEPTH-entry FIFO with wrapping pointers and an occupancy count.
// Head entry is read combinationally; a push is refused while full regardless of pop.
module issue_fifo import issue_pkg::*; #(
  parameter int DEPTH = 4,
  parameter int W     = 32
) (
  input  logic         clk,
  input  logic         nRST,
  input  logic         flush,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         ready,
  output logic         valid,
  output logic [W-1:0] dout
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [PW-1:0] wptr_reg;
  logic [PW-1:0] rptr_reg;
  logic [CW-1:0] count_reg;
  logic          push_ok;
  logic          pop_ok;

  assign ready   = (count_reg < CW'(DEPTH));
  assign valid   = (count_reg != '0);
  assign push_ok = push && ready;
  assign pop_ok  = pop && valid;
  assign dout    = mem[rptr_reg];

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else if (flush) begin
      wptr_reg  <= '0;
      rptr_reg  <= '0;
      count_reg <= '0;
    end else begin
      if (push_ok) wptr_reg <= wptr_reg + PW'(1);
      if (pop_ok)  rptr_reg <= rptr_reg + PW'(1);
      count_reg <= count_reg + CW'(push_ok) - CW'(pop_ok);
    end
  end

  // Storage carries no reset; contents are only observed through valid.
  always_ff @(posedge clk) begin
    if (push_ok && !flush) mem[wptr_reg] <= din;
  end

endmodule

// File: rtl/issue_unit.sv
// In-order issue stage: queues fetched instructions, decodes the head, resolves
// operand tags and writes the register-status table. Optional CDB bypass: ISSUE_CDB_BYPASS_EN.
module issue_unit import issue_pkg::*; #(
  parameter int DATA_W   = 32,
  parameter int LABEL_W  = 4,
  parameter int IQ_DEPTH = 4
) (
  input  logic               clk,
  input  logic               nRST,
  input  logic               flush,
  input  logic               ins_valid,
  input  logic [31:0]        ins,
  output logic               ins_ready,
  output logic [4:0]         readAddr1,
  output logic [4:0]         readAddr2,
  input  logic [LABEL_W-1:0] labelIn1,
  input  logic [LABEL_W-1:0] labelIn2,
  input  logic [DATA_W-1:0]  dataIn1,
  input  logic [DATA_W-1:0]  dataIn2,
  input  logic               cdb_valid,
  input  logic [LABEL_W-1:0] cdb_label,
  input  logic [DATA_W-1:0]  cdb_data,
  input  logic               rs_ready,
  input  logic [LABEL_W-1:0] rs_label,
  output logic               iss_valid,
  output logic [5:0]         op,
  output logic [5:0]         func,
  output logic [LABEL_W-1:0] label1,
  output logic [LABEL_W-1:0] label2,
  output logic [DATA_W-1:0]  value1,
  output logic [DATA_W-1:0]  value2,
  output logic [4:0]         target,
  output logic [DATA_W-1:0]  imm,
  output logic               rat_we,
  output logic [4:0]         rat_addr,
  output logic [LABEL_W-1:0] rat_label
);

  logic        fifo_valid;
  logic [31:0] head_raw;
  logic [31:0] head_ins;
  issue_pkt_t  pkt;
  logic        byp1;
  logic        byp2;

  issue_fifo #(.DEPTH(IQ_DEPTH), .W(32)) u_fifo (
    .clk   (clk),
    .nRST  (nRST),
    .flush (flush),
    .push  (ins_valid),
    .pop   (rs_ready),
    .din   (ins),
    .ready (ins_ready),
    .valid (fifo_valid),
    .dout  (head_raw)
  );

  // Zero the head when empty so decode outputs read 0 rather than stale storage.
  assign head_ins  = fifo_valid ? head_raw : '0;
  assign pkt       = decode_ins(head_ins);

  assign iss_valid = fifo_valid;
  assign op        = pkt.op;
  assign func      = pkt.func;
  assign target    = pkt.target;
  assign readAddr1 = pkt.rs;
  assign readAddr2 = pkt.rt;
  assign imm       = {{(DATA_W-16){pkt.imm16[15]}}, pkt.imm16};

`ifdef ISSUE_CDB_BYPASS_EN
  assign byp1 = cdb_valid && (labelIn1 != LABEL_W'(LABEL_NONE)) && (labelIn1 == cdb_label);
  assign byp2 = cdb_valid && (labelIn2 != LABEL_W'(LABEL_NONE)) && (labelIn2 == cdb_label);
`else
  logic unused_cdb;
  assign unused_cdb = ^{cdb_valid, cdb_label, cdb_data};
  assign byp1 = 1'b0;
  assign byp2 = 1'b0;
`endif

  // A ready operand carries tag 0 already, so only the bypass case rewrites the tag.
  assign label1 = byp1 ? LABEL_W'(LABEL_NONE) : labelIn1;
  assign label2 = byp2 ? LABEL_W'(LABEL_NONE) : labelIn2;
  assign value1 = byp1 ? cdb_data : dataIn1;
  assign value2 = byp2 ? cdb_data : dataIn2;

  assign rat_we    = fifo_valid && rs_ready && (pkt.target != 5'd0);
  assign rat_addr  = pkt.target;
  assign rat_label = rs_label;

endmodule

// File: tb/tb_issue_unit.sv
// Scenario bench for issue_unit: directed cases plus a randomized run against a queue model.
module tb_issue_unit;

  localparam int DATA_W   = 32;
  localparam int LABEL_W  = 4;
  localparam int IQ_DEPTH = 4;
`ifdef ISSUE_CDB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic               clk;
  logic               nRST;
  logic               flush;
  logic               ins_valid;
  logic [31:0]        ins;
  logic               ins_ready;
  logic [4:0]         readAddr1, readAddr2;
  logic [LABEL_W-1:0] labelIn1, labelIn2;
  logic [DATA_W-1:0]  dataIn1, dataIn2;
  logic               cdb_valid;
  logic [LABEL_W-1:0] cdb_label;
  logic [DATA_W-1:0]  cdb_data;
  logic               rs_ready;
  logic [LABEL_W-1:0] rs_label;
  logic               iss_valid;
  logic [5:0]         op, func;
  logic [LABEL_W-1:0] label1, label2;
  logic [DATA_W-1:0]  value1, value2;
  logic [4:0]         target;
  logic [DATA_W-1:0]  imm;
  logic               rat_we;
  logic [4:0]         rat_addr;
  logic [LABEL_W-1:0] rat_label;

  int chk_cnt  = 0;
  int pass_cnt = 0;

  issue_unit #(.DATA_W(DATA_W), .LABEL_W(LABEL_W), .IQ_DEPTH(IQ_DEPTH)) dut (
    .clk(clk), .nRST(nRST), .flush(flush), .ins_valid(ins_valid), .ins(ins),
    .ins_ready(ins_ready), .readAddr1(readAddr1), .readAddr2(readAddr2),
    .labelIn1(labelIn1), .labelIn2(labelIn2), .dataIn1(dataIn1), .dataIn2(dataIn2),
    .cdb_valid(cdb_valid), .cdb_label(cdb_label), .cdb_data(cdb_data),
    .rs_ready(rs_ready), .rs_label(rs_label), .iss_valid(iss_valid), .op(op),
    .func(func), .label1(label1), .label2(label2), .value1(value1), .value2(value2),
    .target(target), .imm(imm), .rat_we(rat_we), .rat_addr(rat_addr), .rat_label(rat_label)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle_inputs;
    flush = 0; ins_valid = 0; ins = '0; labelIn1 = '0; labelIn2 = '0;
    dataIn1 = '0; dataIn2 = '0; cdb_valid = 0; cdb_label = '0; cdb_data = '0;
    rs_ready = 0; rs_label = '0;
  endtask

  task automatic push_one(input logic [31:0] w);
    ins_valid = 1'b1; ins = w;
    tick;
    ins_valid = 1'b0;
  endtask

  task automatic test_reset;
    nRST = 1'b0;
    idle_inputs;
    repeat (2) @(negedge clk);
    nRST = 1'b1;
    #1;
    chk_cnt++; if (iss_valid !== 1'b0) $display("FAIL reset_iss_valid got %0h want 0", iss_valid); else pass_cnt++;
    chk_cnt++; if (ins_ready !== 1'b1) $display("FAIL reset_ins_ready got %0h want 1", ins_ready); else pass_cnt++;
    chk_cnt++; if (rat_we !== 1'b0) $display("FAIL reset_rat_we got %0h want 0", rat_we); else pass_cnt++;
    chk_cnt++; if ({op, func, target, readAddr1, readAddr2} !== 27'd0)
      $display("FAIL reset_decode got %0h want 0", {op, func, target, readAddr1, readAddr2}); else pass_cnt++;
    chk_cnt++; if (imm !== 32'd0) $display("FAIL reset_imm got %0h want 0", imm); else pass_cnt++;
    tick;
  endtask

  task automatic test_basic;
    rs_ready = 1'b0; ins_valid = 1'b1; ins = 32'h012A4020;
    #1;
    chk_cnt++; if (iss_valid !== 1'b0) $display("FAIL basic_no_passthru got %0h want 0", iss_valid); else pass_cnt++;
    tick;
    ins_valid = 1'b0; labelIn1 = '0; labelIn2 = '0; dataIn1 = 32'd5; dataIn2 = 32'd7;
    rs_ready = 1'b1; rs_label = 4'd3;
    #1;
    chk_cnt++; if (iss_valid !== 1'b1) $display("FAIL basic_iss_valid got %0h want 1", iss_valid); else pass_cnt++;
    chk_cnt++; if (target !== 5'd8) $display("FAIL basic_target got %0d want 8", target); else pass_cnt++;
    chk_cnt++; if ({readAddr1, readAddr2} !== {5'd9, 5'd10})
      $display("FAIL basic_readaddr got %0d/%0d want 9/10", readAddr1, readAddr2); else pass_cnt++;
    chk_cnt++; if ({op, func} !== {6'h00, 6'h20}) $display("FAIL basic_opfunc got %0h/%0h want 0/20", op, func); else pass_cnt++;
    chk_cnt++; if ({value1, value2} !== {32'd5, 32'd7})
      $display("FAIL basic_values got %0d/%0d want 5/7", value1, value2); else pass_cnt++;
    chk_cnt++; if ({label1, label2} !== 8'd0) $display("FAIL basic_labels got %0d/%0d want 0/0", label1, label2); else pass_cnt++;
    chk_cnt++; if ({rat_we, rat_addr, rat_label} !== {1'b1, 5'd8, 4'd3})
      $display("FAIL basic_rat got we=%0d addr=%0d lbl=%0d want 1/8/3", rat_we, rat_addr, rat_label); else pass_cnt++;
    tick;
    rs_ready = 1'b0;
    #1;
    chk_cnt++; if ({iss_valid, rat_we} !== 2'b00) $display("FAIL basic_drained got %0b want 00", {iss_valid, rat_we}); else pass_cnt++;
    tick;
  endtask

  task automatic test_full;
    logic [31:0] w [5];
    for (int i = 0; i < 5; i++) w[i] = {6'h08, 5'd0, 5'(i + 1), 16'(100 + i)};
    rs_ready = 1'b0;
    for (int i = 0; i < IQ_DEPTH; i++) begin
      #1;
      chk_cnt++; if (ins_ready !== 1'b1) $display("FAIL full_ready_%0d got %0h want 1", i, ins_ready); else pass_cnt++;
      push_one(w[i]);
    end
    #1;
    chk_cnt++; if (ins_ready !== 1'b0) $display("FAIL full_not_ready got %0h want 0", ins_ready); else pass_cnt++;
    chk_cnt++; if (target !== 5'd1) $display("FAIL full_head0 got %0d want 1", target); else pass_cnt++;
    // Fifth offer lands in the same cycle as a pop: it must still be refused.
    ins_valid = 1'b1; ins = w[4]; rs_ready = 1'b1;
    tick;
    ins_valid = 1'b0; rs_ready = 1'b0;
    #1;
    chk_cnt++; if (ins_ready !== 1'b1) $display("FAIL full_ready_after_pop got %0h want 1", ins_ready); else pass_cnt++;
    for (int i = 1; i < IQ_DEPTH; i++) begin
      chk_cnt++; if ({iss_valid, target, imm} !== {1'b1, 5'(i + 1), 32'(100 + i)})
        $display("FAIL full_order_%0d got v=%0d t=%0d imm=%0d want 1/%0d/%0d", i, iss_valid, target, imm, i + 1, 100 + i);
      else pass_cnt++;
      rs_ready = 1'b1;
      tick;
      rs_ready = 1'b0;
      #1;
    end
    chk_cnt++; if (iss_valid !== 1'b0) $display("FAIL full_fifth_dropped got %0h want 0", iss_valid); else pass_cnt++;
    tick;
  endtask

  task automatic test_bypass;
    rs_ready = 1'b0;
    push_one(32'h2084FFFF);
    labelIn1 = 4'd5; cdb_valid = 1'b1; cdb_label = 4'd5; cdb_data = 32'd42; dataIn1 = 32'd99;
    labelIn2 = 4'd6; dataIn2 = 32'd77;
    #1;
    chk_cnt++; if (label1 !== (BYP ? 4'd0 : 4'd5)) $display("FAIL bypass_label1 got %0d want %0d", label1, BYP ? 0 : 5); else pass_cnt++;
    chk_cnt++; if (value1 !== (BYP ? 32'd42 : 32'd99)) $display("FAIL bypass_value1 got %0d want %0d", value1, BYP ? 42 : 99); else pass_cnt++;
    chk_cnt++; if ({label2, value2} !== {4'd6, 32'd77}) $display("FAIL bypass_nomatch got %0d/%0d want 6/77", label2, value2); else pass_cnt++;
    chk_cnt++; if (imm !== 32'hFFFFFFFF) $display("FAIL bypass_imm got %0h want ffffffff", imm); else pass_cnt++;
    chk_cnt++; if (target !== 5'd4) $display("FAIL bypass_target got %0d want 4", target); else pass_cnt++;
    rs_ready = 1'b1; rs_label = 4'd2;
    #1;
    chk_cnt++; if ({rat_we, rat_addr, rat_label} !== {1'b1, 5'd4, 4'd2})
      $display("FAIL bypass_rat got %0d/%0d/%0d want 1/4/2", rat_we, rat_addr, rat_label); else pass_cnt++;
    tick;
    idle_inputs;
  endtask

  task automatic test_target_zero;
    rs_ready = 1'b0;
    push_one({6'h00, 5'd1, 5'd2, 5'd0, 5'd0, 6'h20});
    rs_ready = 1'b1; rs_label = 4'd7;
    #1;
    chk_cnt++; if ({iss_valid, target, rat_we} !== {1'b1, 5'd0, 1'b0})
      $display("FAIL tzero_rat got v=%0d t=%0d we=%0d want 1/0/0", iss_valid, target, rat_we); else pass_cnt++;
    tick;
    rs_ready = 1'b0;
    #1;
    chk_cnt++; if (iss_valid !== 1'b0) $display("FAIL tzero_popped got %0h want 0", iss_valid); else pass_cnt++;
    tick;
  endtask

  task automatic test_flush;
    rs_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one({6'h08, 5'd0, 5'(20 + i), 16'd0});
    #1;
    chk_cnt++; if ({iss_valid, target} !== {1'b1, 5'd20}) $display("FAIL flush_pre got %0d/%0d want 1/20", iss_valid, target); else pass_cnt++;
    flush = 1'b1; ins_valid = 1'b1; ins = {6'h08, 5'd0, 5'd30, 16'd0};
    tick;
    flush = 1'b0; ins_valid = 1'b0;
    #1;
    chk_cnt++; if ({iss_valid, ins_ready} !== 2'b01) $display("FAIL flush_cleared got %0b want 01", {iss_valid, ins_ready}); else pass_cnt++;
    push_one({6'h08, 5'd0, 5'd17, 16'd0});
    #1;
    chk_cnt++; if ({iss_valid, target} !== {1'b1, 5'd17}) $display("FAIL flush_repush got %0d/%0d want 1/17", iss_valid, target); else pass_cnt++;
    rs_ready = 1'b1;
    tick;
    rs_ready = 1'b0;
  endtask

  task automatic test_reset_mid;
    rs_ready = 1'b0;
    for (int i = 0; i < 3; i++) push_one({6'h08, 5'd0, 5'(5 + i), 16'd0});
    #2 nRST = 1'b0;
    #1;
    chk_cnt++; if ({iss_valid, ins_ready} !== 2'b01) $display("FAIL rstmid_async got %0b want 01", {iss_valid, ins_ready}); else pass_cnt++;
    rs_ready = 1'b1; rs_label = 4'd9;
    #1;
    chk_cnt++; if (rat_we !== 1'b0) $display("FAIL rstmid_rat_in got %0h want 0", rat_we); else pass_cnt++;
    @(negedge clk);
    nRST = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      chk_cnt++; if ({iss_valid, rat_we} !== 2'b00) $display("FAIL rstmid_after_%0d got %0b want 00", i, {iss_valid, rat_we}); else pass_cnt++;
      tick;
    end
    rs_ready = 1'b0;
  endtask

  task automatic test_random;
    logic [31:0]        q[$];
    logic [31:0]        r, h;
    logic [4:0]         et;
    logic [LABEL_W-1:0] el1, el2;
    logic [DATA_W-1:0]  ev1, ev2, eimm;
    logic               ev, er, erat, do_pop, do_push;
    for (int c = 0; c < 400; c++) begin
      flush     = ($urandom_range(0, 24) == 0);
      ins_valid = 1'($urandom_range(0, 2) != 0);
      r = $urandom;
      if ($urandom_range(0, 1) == 0) r[31:26] = 6'h00;
      ins       = r;
      labelIn1  = ($urandom_range(0, 2) == 0) ? '0 : LABEL_W'($urandom);
      labelIn2  = ($urandom_range(0, 2) == 0) ? '0 : LABEL_W'($urandom);
      dataIn1   = $urandom;
      dataIn2   = $urandom;
      cdb_valid = 1'($urandom_range(0, 1));
      cdb_label = ($urandom_range(0, 1) == 0) ? labelIn1 : LABEL_W'($urandom);
      cdb_data  = $urandom;
      rs_ready  = flush ? 1'b0 : 1'($urandom_range(0, 1));
      rs_label  = LABEL_W'($urandom_range(1, 15));
      #1;
      ev = (q.size() != 0);
      er = (q.size() < IQ_DEPTH);
      h  = ev ? q[0] : 32'd0;
      et = (h[31:26] == 6'h00) ? h[15:11] : h[20:16];
      eimm = {{16{h[15]}}, h[15:0]};
      el1 = labelIn1; ev1 = dataIn1;
      el2 = labelIn2; ev2 = dataIn2;
      if (BYP && cdb_valid && labelIn1 != 0 && labelIn1 == cdb_label) begin el1 = '0; ev1 = cdb_data; end
      if (BYP && cdb_valid && labelIn2 != 0 && labelIn2 == cdb_label) begin el2 = '0; ev2 = cdb_data; end
      erat = ev && rs_ready && (et != 5'd0);
      chk_cnt++; if ({iss_valid, ins_ready, rat_we} !== {ev, er, erat})
        $display("FAIL rand_ctrl_%0d got %03b want %03b", c, {iss_valid, ins_ready, rat_we}, {ev, er, erat});
      else pass_cnt++;
      if (ev) begin
        chk_cnt++;
        if ({op, func, target, imm, readAddr1, readAddr2, label1, label2, value1, value2, rat_addr, rat_label} !==
            {h[31:26], h[5:0], et, eimm, h[25:21], h[20:16], el1, el2, ev1, ev2, et, rs_label})
          $display("FAIL rand_data_%0d got %h want %h", c,
            {op, func, target, imm, readAddr1, readAddr2, label1, label2, value1, value2, rat_addr, rat_label},
            {h[31:26], h[5:0], et, eimm, h[25:21], h[20:16], el1, el2, ev1, ev2, et, rs_label});
        else pass_cnt++;
      end
      do_pop  = ev && rs_ready;
      do_push = ins_valid && er;
      if (flush) begin
        q.delete();
        $display("cycle %0d flush", c);
      end else begin
        if (do_pop) begin
          $display("cycle %0d issue ins=%08h target=%0d rat_we=%0d", c, h, et, erat);
          void'(q.pop_front());
        end
        if (do_push) q.push_back(ins);
      end
      tick;
    end
    idle_inputs;
  endtask

  initial begin
    nRST = 1'b0;
    idle_inputs;
    test_reset;
    test_basic;
    test_full;
    test_bypass;
    test_target_zero;
    test_flush;
    test_reset_mid;
    test_random;
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end

endmodule
